i2c_xfer_arb: RTL and testbench



---
 rtl/i2c_pkg.sv | 67 ++++++
 rtl/i2c_xfer_arb_if.sv | 40 ++++
 rtl/i2c_rr_arb.sv | 43 ++++
 rtl/i2c_xfer_arb.sv | 193 +++++++++++++++++++
 tb/tb_i2c_xfer_arb.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C transfer arbiter:
//                FSM states, TX FIFO word layout, per-direction word counts
//                and the helper that builds each TX FIFO word.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Controller states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_WAIT_RX  = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // TX FIFO word layout: {STOP, START, byte}
    localparam int TX_STOP_BIT  = 9;
    localparam int TX_START_BIT = 8;

    // Words issued per transaction
    localparam int WR_WORDS = 3;
    localparam int RD_WORDS = 4;

    // Completion timeout counter width
    localparam int CNT_W = 20;

    // Build the TX FIFO word for position idx of a write or read sequence.
    // Write: START+dev/W, reg, STOP+data.
    // Read : START+dev/W, reg, repeated START+dev/R, STOP+byte count 1.
    function automatic logic [9:0] tx_word(input logic       we,
                                           input logic [1:0] idx,
                                           input logic [6:0] dev,
                                           input logic [7:0] rg,
                                           input logic [7:0] wd);
        logic [9:0] w;
        w = '0;
        case (idx)
            2'd0: begin
                w[TX_START_BIT] = 1'b1;
                w[7:0]          = {dev, 1'b0};
            end
            2'd1: begin
                w[7:0] = rg;
            end
            2'd2: begin
                if (we) begin
                    w[TX_STOP_BIT] = 1'b1;
                    w[7:0]         = wd;
                end else begin
                    w[TX_START_BIT] = 1'b1;
                    w[7:0]          = {dev, 1'b1};
                end
            end
            default: begin
                w[TX_STOP_BIT] = 1'b1;
                w[7:0]         = 8'd1;
            end
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_xfer_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_xfer_arb_if
//  Description : Requester and I2C core FIFO/status signals of the transfer
//                arbiter. slave = arbiter side, master = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_xfer_arb_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] dev_adr;
    logic [15:0] reg_adr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic        tx_fifo_wr;
    logic [9:0]  tx_fifo_din;
    logic [4:0]  tx_fifo_ocy;
    logic        rx_fifo_rd;
    logic [7:0]  rx_fifo_dout;
    logic [4:0]  rx_fifo_ocy;
    logic        bus_busy;
    logic        irq_al;
    logic        irq_nas;

    modport slave (
        input  req, we, dev_adr, reg_adr, wdata,
        input  tx_fifo_ocy, rx_fifo_dout, rx_fifo_ocy, bus_busy, irq_al, irq_nas,
        output gnt, done, err, rdata, tx_fifo_wr, tx_fifo_din, rx_fifo_rd
    );

    modport master (
        output req, we, dev_adr, reg_adr, wdata,
        output tx_fifo_ocy, rx_fifo_dout, rx_fifo_ocy, bus_busy, irq_al, irq_nas,
        input  gnt, done, err, rdata, tx_fifo_wr, tx_fifo_din, rx_fifo_rd
    );
endinterface
`default_nettype wire

// File: rtl/i2c_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rr_arb
//  Description : 2-way round-robin arbiter. The requester not granted last
//                wins a tie; the pointer starts at requester 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_arb (
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic [1:0] req_i,
    input  wire logic       accept_i,
    output logic      [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Winner selection: pointed requester first, otherwise the other one
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (req_i[ptr_q]) begin
            gnt_o[ptr_q] = 1'b1;
        end else if (req_i[~ptr_q]) begin
            gnt_o[~ptr_q] = 1'b1;
        end
        if (accept_i && (|gnt_o)) begin
            ptr_d = gnt_o[0];
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_xfer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_xfer_arb
//  Description : Arbitrates two register-access requesters onto one I2C core,
//                pushes the START/STOP-framed byte sequence into the core TX
//                FIFO, collects the read byte and reports completion/error.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_xfer_arb
    import i2c_pkg::*;
#(
    parameter int unsigned TO_CYC = 200000,
    parameter int unsigned NREQ   = 2
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    i2c_xfer_arb_if.slave   xif
);

    state_t            state_q,  state_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [1:0]        done_q,   done_d;
    logic              err_q,    err_d;
    logic [7:0]        rdata_q,  rdata_d;
    logic              tx_wr_q,  tx_wr_d;
    logic [9:0]        tx_din_q, tx_din_d;
    logic              rx_rd_q,  rx_rd_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [1:0]        idx_q,    idx_d;
    logic              we_q,     we_d;
    logic [6:0]        dev_q,    dev_d;
    logic [7:0]        reg_q,    reg_d;
    logic [7:0]        wdat_q,   wdat_d;
    logic              quiet_q,  quiet_d;

    logic [1:0]        w_arb_gnt;
    logic              w_accept;
    logic              w_sel;
    logic              w_room;
    logic              w_last;
    logic              w_quiet;
    logic              w_abort;

    assign w_accept = (state_q == ST_IDLE) && (|xif.req);
    assign w_sel    = w_arb_gnt[1];

    i2c_rr_arb u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req_i    (xif.req),
        .accept_i (w_accept),
        .gnt_o    (w_arb_gnt)
    );

    // A word whose strobe is high this cycle is not yet in tx_fifo_ocy
    assign w_room  = ({1'b0, xif.tx_fifo_ocy} + {5'd0, tx_wr_q}) < 6'd16;
    assign w_last  = (idx_q == (we_q ? 2'(WR_WORDS - 1) : 2'(RD_WORDS - 1)));
    assign w_quiet = (xif.tx_fifo_ocy == 5'd0) && !xif.bus_busy && !tx_wr_q;
    assign w_abort = xif.irq_al || xif.irq_nas || (cnt_q == CNT_W'(TO_CYC - 1));

    // Next-state and output logic; errors take precedence over progress
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        tx_wr_d  = 1'b0;
        tx_din_d = tx_din_q;
        rx_rd_d  = 1'b0;
        idx_d    = idx_q;
        we_d     = we_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdat_d   = wdat_q;
        quiet_d  = quiet_q;
        cnt_d    = cnt_q;
        if ((state_q != ST_IDLE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    gnt_d   = w_arb_gnt;
                    we_d    = xif.we[w_sel];
                    dev_d   = w_sel ? xif.dev_adr[13:7] : xif.dev_adr[6:0];
                    reg_d   = w_sel ? xif.reg_adr[15:8] : xif.reg_adr[7:0];
                    wdat_d  = w_sel ? xif.wdata[15:8]   : xif.wdata[7:0];
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    quiet_d = 1'b0;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (w_abort) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (w_room) begin
                    tx_wr_d  = 1'b1;
                    tx_din_d = tx_word(we_q, idx_q, dev_q, reg_q, wdat_q);
                    idx_d    = idx_q + 2'd1;
                    if (w_last) begin
                        state_d = we_q ? ST_WAIT_END : ST_WAIT_RX;
                    end
                end
            end
            ST_WAIT_RX: begin
                if (w_abort) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (xif.rx_fifo_ocy != 5'd0) begin
                    rx_rd_d = 1'b1;
                    rdata_d = xif.rx_fifo_dout;
                    state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (w_abort) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (w_quiet) begin
                    quiet_d = 1'b1;
                    if (quiet_q) begin
                        done_d  = gnt_q;
                        state_d = ST_FINISH;
                    end
                end else begin
                    quiet_d = 1'b0;
                end
            end
            ST_FINISH: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= 8'd0;
            tx_wr_q  <= 1'b0;
            tx_din_q <= 10'd0;
            rx_rd_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            we_q     <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            wdat_q   <= 8'd0;
            quiet_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            tx_wr_q  <= tx_wr_d;
            tx_din_q <= tx_din_d;
            rx_rd_q  <= rx_rd_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdat_q   <= wdat_d;
            quiet_q  <= quiet_d;
        end
    end

    assign xif.gnt         = gnt_q;
    assign xif.done        = done_q;
    assign xif.err         = err_q;
    assign xif.rdata       = rdata_q;
    assign xif.tx_fifo_wr  = tx_wr_q;
    assign xif.tx_fifo_din = tx_din_q;
    assign xif.rx_fifo_rd  = rx_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_xfer_arb
//  Description : Bench for i2c_xfer_arb with a TX/RX FIFO plus bus-slave
//                model, directed scenarios and randomized transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_xfer_arb;

    localparam int TO = 100;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_xfer_arb_if xif();

    i2c_xfer_arb #(.TO_CYC(TO), .NREQ(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .xif  (xif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [9:0] tx_q[$];
    logic [9:0] tx_log[$];
    logic [7:0] rx_q[$];
    int         fill_n     = 0;
    bit         drain_en   = 1'b0;
    bit         force_busy = 1'b0;
    bit         rd_phase   = 1'b0;
    logic [7:0] rx_next    = 8'h00;
    logic [7:0] rx_last    = 8'h00;
    int         rd_cnt     = 0;
    int         ovf        = 0;
    int         rx_under   = 0;
    int         last_gnt   = 1;
    logic [7:0] rdata_exp  = 8'h00;

    logic       r_we  [2];
    logic [6:0] r_dev [2];
    logic [7:0] r_reg [2];
    logic [7:0] r_dat [2];

    assign xif.bus_busy = force_busy | (xif.tx_fifo_ocy != 5'd0);

    // FIFO and bus-slave model: words drain in order; the STOP after a
    // read-addressed START returns one byte into the RX FIFO.
    always @(posedge clk) begin
        logic [9:0] w;
        if (xif.tx_fifo_wr) begin
            if (tx_q.size() >= 16) ovf++;
            tx_q.push_back(xif.tx_fifo_din);
            tx_log.push_back(xif.tx_fifo_din);
        end
        if (xif.rx_fifo_rd) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else rx_under++;
            rd_cnt++;
        end
        while (fill_n > 0) begin
            tx_q.push_back(10'h000);
            fill_n--;
        end
        if (drain_en && tx_q.size() != 0 && $urandom_range(0, 3) != 0) begin
            w = tx_q.pop_front();
            if (w[8]) rd_phase = w[0];
            if (w[9] && rd_phase) begin
                rx_q.push_back(rx_next);
                rx_last  = rx_next;
                rd_phase = 1'b0;
            end
        end
        xif.tx_fifo_ocy  <= 5'(tx_q.size());
        xif.rx_fifo_ocy  <= 5'(rx_q.size());
        xif.rx_fifo_dout <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic w, input logic [6:0] d,
                           input logic [7:0] g, input logic [7:0] v);
        r_we[r]  = w;
        r_dev[r] = d;
        r_reg[r] = g;
        r_dat[r] = v;
        xif.we[r]              = w;
        xif.dev_adr[r*7 +: 7]  = d;
        xif.reg_adr[r*8 +: 8]  = g;
        xif.wdata[r*8 +: 8]    = v;
        xif.req[r]             = 1'b1;
    endtask

    // Round-robin reference: a tie goes to the requester not granted last
    function automatic int pick(input logic [1:0] rq);
        if (rq == 2'b11) return 1 - last_gnt;
        return rq[1] ? 1 : 0;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_gnt"},    32'(xif.gnt), 0);
        check_eq({pfx, "_done"},   32'(xif.done), 0);
        check_eq({pfx, "_err"},    32'(xif.err), 0);
        check_eq({pfx, "_rdata"},  32'(xif.rdata), 0);
        check_eq({pfx, "_txwr"},   32'(xif.tx_fifo_wr), 0);
        check_eq({pfx, "_txdin"},  32'(xif.tx_fifo_din), 0);
        check_eq({pfx, "_rxrd"},   32'(xif.rx_fifo_rd), 0);
    endtask

    // Follow one transaction of requester r from grant to done and check it
    task automatic serve(input int r);
        int         k;
        int         n;
        logic [9:0] exp_w [4];
        k = 0;
        while (xif.gnt == 2'b00 && k < 20) begin @(negedge clk); k++; end
        check_eq("gnt_onehot", 32'(xif.gnt), 32'd1 << r);
        last_gnt = r;
        k = 0;
        while (xif.done == 2'b00 && k < TO + 50) begin @(negedge clk); k++; end
        check_eq("done_bit", 32'(xif.done), 32'd1 << r);
        check_eq("err_ok", 32'(xif.err), 0);
        xif.req[r] = 1'b0;
        exp_w[0] = {2'b01, r_dev[r], 1'b0};
        exp_w[1] = {2'b00, r_reg[r]};
        if (r_we[r]) begin
            exp_w[2] = {2'b10, r_dat[r]};
            exp_w[3] = 10'h000;
            n = 3;
            check_eq("rdata_hold", 32'(xif.rdata), 32'(rdata_exp));
            check_eq("rx_pops_wr", rd_cnt, 0);
        end else begin
            exp_w[2] = {2'b01, r_dev[r], 1'b1};
            exp_w[3] = {2'b10, 8'h01};
            n = 4;
            check_eq("rdata", 32'(xif.rdata), 32'(rx_last));
            check_eq("rx_pops_rd", rd_cnt, 1);
            rdata_exp = rx_last;
        end
        check_eq("n_words", tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            check_eq($sformatf("word%0d", i), 32'(tx_log[i]), 32'(exp_w[i]));
        end
        @(negedge clk);
        check_eq("done_pulse", 32'(xif.done), 0);
        check_eq("gnt_drop", 32'(xif.gnt), 0);
        tx_log.delete();
        rd_cnt  = 0;
        rx_next = 8'($urandom);
    endtask

    task automatic wait_tx_empty(input string tag);
        int k;
        k = 0;
        while ((xif.tx_fifo_ocy != 5'd0 || xif.bus_busy) && k < 200) begin @(negedge clk); k++; end
        check_eq(tag, 32'(xif.tx_fifo_ocy), 0);
        tx_log.delete();
        rd_cnt = 0;
    endtask

    initial begin
        int         k;
        int         mode;
        int         first;
        logic [1:0] rq;

        xif.req     = 2'b00;
        xif.we      = 2'b00;
        xif.dev_adr = '0;
        xif.reg_adr = '0;
        xif.wdata   = '0;
        xif.irq_al  = 1'b0;
        xif.irq_nas = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn     = 1'b1;
        drain_en = 1'b1;
        rx_next  = 8'($urandom);
        @(negedge clk);

        // Simultaneous requests from reset: 0, 1, then 0 again
        set_req(0, 1'b1, 7'h21, 8'h01, 8'h11);
        set_req(1, 1'b1, 7'h22, 8'h02, 8'h22);
        serve(0);
        serve(1);
        set_req(0, 1'b0, 7'h23, 8'h03, 8'h00);
        set_req(1, 1'b1, 7'h24, 8'h04, 8'h44);
        serve(0);
        serve(1);

        // Write dev 0x50 reg 0x12 data 0xA5 with grant/push latency
        set_req(0, 1'b1, 7'h50, 8'h12, 8'hA5);
        @(negedge clk);
        check_eq("s1_gnt_lat", 32'(xif.gnt), 32'h1);
        @(negedge clk);
        check_eq("s1_wr_lat", 32'(xif.tx_fifo_wr), 32'h1);
        check_eq("s1_word0", 32'(xif.tx_fifo_din), 32'h1A0);
        serve(0);

        // Read dev 0x50 reg 0x34 returning 0x5C
        rx_next = 8'h5C;
        set_req(1, 1'b0, 7'h50, 8'h34, 8'h00);
        serve(1);
        check_eq("s2_rdata", 32'(xif.rdata), 32'h5C);

        // TX FIFO at 15: one word, then stall until it drains
        drain_en = 1'b0;
        fill_n   = 15;
        repeat (2) @(negedge clk);
        check_eq("s4_ocy", 32'(xif.tx_fifo_ocy), 15);
        set_req(0, 1'b1, 7'h3C, 8'h40, 8'h5A);
        repeat (12) @(negedge clk);
        check_eq("s4_stall_words", tx_log.size(), 1);
        check_eq("s4_ocy_full", 32'(xif.tx_fifo_ocy), 16);
        check_eq("s4_gnt", 32'(xif.gnt), 32'h1);
        drain_en = 1'b1;
        serve(0);

        // NACK while waiting for the bus to go idle
        drain_en = 1'b0;
        set_req(1, 1'b1, 7'h11, 8'h22, 8'h33);
        k = 0;
        while (tx_log.size() < 3 && k < 30) begin @(negedge clk); k++; end
        check_eq("s5_words", tx_log.size(), 3);
        last_gnt = 1;
        repeat (2) @(negedge clk);
        check_eq("s5_no_done", 32'(xif.done), 0);
        xif.irq_nas = 1'b1;
        @(negedge clk);
        xif.irq_nas = 1'b0;
        check_eq("s5_done", 32'(xif.done), 32'h2);
        check_eq("s5_err", 32'(xif.err), 32'h1);
        check_eq("s5_rdata_hold", 32'(xif.rdata), 32'(rdata_exp));
        @(negedge clk);
        check_eq("s5_done_pulse", 32'(xif.done), 0);
        xif.req[1] = 1'b0;
        drain_en   = 1'b1;
        wait_tx_empty("s5_drain");

        // Randomized traffic: single requests and simultaneous pairs
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            rq   = (mode == 0) ? 2'b01 : (mode == 1) ? 2'b10 : 2'b11;
            for (int r = 0; r < 2; r++) begin
                if (rq[r]) set_req(r, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            end
            first = pick(rq);
            serve(first);
            if (mode == 2) serve(1 - first);
        end

        // Bus stuck busy: timeout exactly TO cycles after grant
        force_busy = 1'b1;
        set_req(0, 1'b1, 7'h55, 8'h66, 8'h77);
        @(negedge clk);
        check_eq("s6_gnt", 32'(xif.gnt), 32'h1);
        last_gnt = 0;
        k = 0;
        while (xif.done == 2'b00 && k < 3 * TO) begin @(negedge clk); k++; end
        check_eq("s6_to_cycle", k, TO);
        check_eq("s6_done", 32'(xif.done), 32'h1);
        check_eq("s6_err", 32'(xif.err), 32'h1);
        @(negedge clk);
        xif.req[0] = 1'b0;
        force_busy = 1'b0;
        wait_tx_empty("s6_drain");

        // Reset while stalled in PUSH
        drain_en = 1'b0;
        fill_n   = 15;
        repeat (2) @(negedge clk);
        set_req(1, 1'b0, 7'h0F, 8'hF0, 8'h00);
        repeat (4) @(negedge clk);
        check_eq("rst_pre_gnt", 32'(xif.gnt), 32'h2);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        xif.req = 2'b00;
        @(negedge clk);
        rstn     = 1'b1;
        last_gnt = 1;
        repeat (5) @(negedge clk);
        check_eq("post_rst_done", 32'(xif.done), 0);
        check_eq("post_rst_gnt", 32'(xif.gnt), 0);

        check_eq("tx_overflow", ovf, 0);
        check_eq("rx_underflow", rx_under, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
